// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared types and constants for the scope acquisition stage.
//   state_t        : capture FSM states
//   EDGE_RISE/FALL : encoding of the trig_edge_i select
//   DEFAULT_*      : default sample / address widths
//   is_busy()      : true for the states in which samples are captured
// -----------------------------------------------------------------------------
package scope_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 9;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POSTFILL,
        DONE
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == PREFILL) || (s == WAIT_TRIG) || (s == POSTFILL);
    endfunction

endpackage

// File: rtl/scope_trigger_capture_if.sv
// -----------------------------------------------------------------------------
// scope_trigger_capture_if
// Bundles the sample stream, the capture controls, the capture-RAM write
// bus and the status/readout outputs of the acquisition stage.
//   master : the producer side (ADC stream and control source)
//   slave  : the capture block itself
// -----------------------------------------------------------------------------
interface scope_trigger_capture_if #(
    parameter int DATA_W = scope_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = scope_pkg::DEFAULT_ADDR_W
) ();

    // Sample stream and capture controls
    logic [DATA_W-1:0] sample_i;
    logic              sample_valid_i;
    logic              arm_i;
    logic              force_i;
    logic [DATA_W-1:0] trig_level_i;
    logic              trig_edge_i;
    logic [ADDR_W-1:0] pretrig_i;

    // Capture RAM write bus
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;

    // Status and readout pointers
    logic              busy_o;
    logic              triggered_o;
    logic              done_o;
    logic [ADDR_W-1:0] trig_addr_o;
    logic [ADDR_W-1:0] start_addr_o;

    modport master (
        output sample_i, sample_valid_i, arm_i, force_i,
               trig_level_i, trig_edge_i, pretrig_i,
        input  mem_we_o, mem_addr_o, mem_data_o,
               busy_o, triggered_o, done_o, trig_addr_o, start_addr_o
    );

    modport slave (
        input  sample_i, sample_valid_i, arm_i, force_i,
               trig_level_i, trig_edge_i, pretrig_i,
        output mem_we_o, mem_addr_o, mem_data_o,
               busy_o, triggered_o, done_o, trig_addr_o, start_addr_o
    );

endinterface

// File: rtl/scope_edge_detect.sv
// -----------------------------------------------------------------------------
// scope_edge_detect
// Keeps the previously accepted sample and reports a level crossing between
// it and the current sample.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : forget the previous sample (new capture armed)
//   accept    : cur is an accepted sample; it becomes the new previous sample
//   cur       : current sample
//   level     : unsigned trigger threshold
//   edge_sel  : EDGE_RISE or EDGE_FALL
//   hit       : combinational crossing indication for cur against prev
// -----------------------------------------------------------------------------
module scope_edge_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,
    output logic              hit
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;

    // prev_valid stays low until one sample has been seen after arming, so
    // the first sample of a capture can never be the crossing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (accept) begin
            prev       <= cur;
            prev_valid <= 1'b1;
        end
    end

    // The crossing sample is the one that reaches or passes the level.
    always_comb begin
        hit = 1'b0;
        if (prev_valid) begin
            if (edge_sel == EDGE_FALL) begin
                hit = (prev > level) && (cur <= level);
            end else begin
                hit = (prev < level) && (cur >= level);
            end
        end
    end

endmodule

// File: rtl/scope_trigger_capture.sv
// -----------------------------------------------------------------------------
// scope_trigger_capture
// Acquisition stage of the scope: fills a circular capture RAM with a
// programmable number of pre-trigger samples, waits for a level crossing
// (or a forced trigger), completes the post-trigger fill and then reports
// the oldest sample address for the readout stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of scope_trigger_capture_if
//              inputs  sample_i, sample_valid_i, arm_i, force_i,
//                      trig_level_i, trig_edge_i, pretrig_i
//              outputs mem_we_o, mem_addr_o, mem_data_o (RAM write bus),
//                      busy_o, triggered_o, done_o, trig_addr_o, start_addr_o
// All outputs are registered.
// -----------------------------------------------------------------------------
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    scope_trigger_capture_if.slave  bus
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] MAX_PRE = ADDR_W'(DEPTH - 1);

    // Limits the pre-trigger depth so at least the trigger sample fits.
    function automatic logic [ADDR_W-1:0] clamp_pretrig(input logic [ADDR_W-1:0] p);
        if ({1'b0, p} > (ADDR_W + 1)'(DEPTH - 1)) begin
            return MAX_PRE;
        end
        return p;
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] pretrig_lat;

    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r;
    logic              busy_r;
    logic              triggered_r;
    logic              done_r;
    logic [ADDR_W-1:0] trig_addr_r;
    logic [ADDR_W-1:0] start_addr_r;

    logic              accept;
    logic              edge_hit;
    logic [ADDR_W-1:0] pretrig_clamped;
    logic [ADDR_W-1:0] post_load;

    // A sample is taken only while capturing; the arm cycle never takes one.
    assign accept          = bus.sample_valid_i && is_busy(state) && !bus.arm_i;
    assign pretrig_clamped = clamp_pretrig(bus.pretrig_i);
    assign post_load       = MAX_PRE - pretrig_lat;

    scope_edge_detect #(
        .DATA_W (DATA_W)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.arm_i),
        .accept   (accept),
        .cur      (bus.sample_i),
        .level    (bus.trig_level_i),
        .edge_sel (bus.trig_edge_i),
        .hit      (edge_hit)
    );

    // Capture FSM with pointer, counters and all registered outputs.
    // Every accepted sample is written at ptr and ptr advances modulo DEPTH,
    // so once the capture finishes ptr already points at the oldest sample
    // and becomes start_addr_o on the same edge as the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            pretrig_lat  <= '0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            busy_r       <= 1'b0;
            triggered_r  <= 1'b0;
            done_r       <= 1'b0;
            trig_addr_r  <= '0;
            start_addr_r <= '0;
        end else begin
            mem_we_r <= 1'b0;

            if (bus.arm_i) begin
                pretrig_lat <= pretrig_clamped;
                ptr         <= '0;
                pre_cnt     <= '0;
                post_cnt    <= '0;
                triggered_r <= 1'b0;
                done_r      <= 1'b0;
                busy_r      <= 1'b1;
                state       <= (pretrig_clamped == '0) ? WAIT_TRIG : PREFILL;
            end else if (accept) begin
                mem_we_r   <= 1'b1;
                mem_addr_r <= ptr;
                mem_data_r <= bus.sample_i;
                ptr        <= ptr + 1'b1;

                case (state)
                    PREFILL: begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt + 1'b1 == pretrig_lat) begin
                            state <= WAIT_TRIG;
                        end
                    end

                    WAIT_TRIG: begin
                        // Force and crossing on the same sample are one trigger.
                        if (edge_hit || bus.force_i) begin
                            trig_addr_r <= ptr;
                            triggered_r <= 1'b1;
                            if (post_load == '0) begin
                                state        <= DONE;
                                done_r       <= 1'b1;
                                busy_r       <= 1'b0;
                                start_addr_r <= ptr + 1'b1;
                            end else begin
                                post_cnt <= post_load;
                                state    <= POSTFILL;
                            end
                        end
                    end

                    POSTFILL: begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            state        <= DONE;
                            done_r       <= 1'b1;
                            busy_r       <= 1'b0;
                            start_addr_r <= ptr + 1'b1;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.mem_we_o     = mem_we_r;
    assign bus.mem_addr_o   = mem_addr_r;
    assign bus.mem_data_o   = mem_data_r;
    assign bus.busy_o       = busy_r;
    assign bus.triggered_o  = triggered_r;
    assign bus.done_o       = done_r;
    assign bus.trig_addr_o  = trig_addr_r;
    assign bus.start_addr_o = start_addr_r;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// -----------------------------------------------------------------------------
// tb_scope_trigger_capture
// Directed bench for scope_trigger_capture with a 16-entry capture RAM.
// Inputs change just after the falling edge, outputs are checked one
// nanosecond after the following falling edge, and a write monitor on the
// falling edge counts RAM writes and mirrors the written data.
// -----------------------------------------------------------------------------
module tb_scope_trigger_capture;
    import scope_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;
    int wr_count;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] mem_img [16];

    scope_trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

    scope_trigger_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor
    always @(negedge clk) begin
        if (sif.mem_we_o === 1'b1) begin
            wr_count = wr_count + 1;
            last_addr = sif.mem_addr_o;
            mem_img[sif.mem_addr_o] = sif.mem_data_o;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One clock: drive the inputs, let the edge happen, resume after negedge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic f);
        sif.sample_valid_i = v;
        sif.sample_i       = d;
        sif.force_i        = f;
        @(posedge clk);
        @(negedge clk);
        #1;
        sif.sample_valid_i = 1'b0;
        sif.force_i        = 1'b0;
    endtask

    task automatic do_arm(input logic [ADDR_W-1:0] pre, input logic [DATA_W-1:0] lvl, input logic edg);
        sif.pretrig_i    = pre;
        sif.trig_level_i = lvl;
        sif.trig_edge_i  = edg;
        sif.arm_i        = 1'b1;
        cycle(1'b0, '0, 1'b0);
        sif.arm_i        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        tests_run++; if (sif.mem_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we: got %b expected 0", sif.mem_we_o); end
        tests_run++; if (sif.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", sif.busy_o); end
        tests_run++; if (sif.done_o !== 1'b0 || sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got done=%b trig=%b expected 0/0", sif.done_o, sif.triggered_o); end
        tests_run++; if (sif.trig_addr_o !== 4'h0 || sif.start_addr_o !== 4'h0 || sif.mem_addr_o !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_addrs: got %h/%h/%h expected 0/0/0", sif.trig_addr_o, sif.start_addr_o, sif.mem_addr_o); end
        rst = 1'b0;
        // IDLE ignores samples and force
        cycle(1'b1, 8'hCC, 1'b1);
        tests_run++; if (sif.mem_we_o !== 1'b0 || sif.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_ignore: got we=%b busy=%b expected 0/0", sif.mem_we_o, sif.busy_o); end
    endtask

    task automatic test_rising_ramp();
        int base;
        base = wr_count;
        do_arm(4'd4, 8'h80, EDGE_RISE);
        tests_run++; if (sif.busy_o !== 1'b1 || sif.mem_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_arm: got busy=%b we=%b expected 1/0", sif.busy_o, sif.mem_we_o); end
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i * 16), 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_pre_trig: got %b expected 0", sif.triggered_o); end
        cycle(1'b1, 8'h80, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.trig_addr_o !== 4'd8) begin tests_failed++; $display("[TB] FAIL ramp_trig: got trig=%b addr=%0d expected 1/8", sif.triggered_o, sif.trig_addr_o); end
        for (int i = 9; i < 19; i++) cycle(1'b1, 8'(i * 16), 1'b0);
        tests_run++; if (sif.done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_early_done: got %b expected 0", sif.done_o); end
        cycle(1'b1, 8'h30, 1'b0);
        tests_run++; if (sif.done_o !== 1'b1 || sif.mem_we_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_done_last_write: got done=%b we=%b expected 1/1", sif.done_o, sif.mem_we_o); end
        tests_run++; if (sif.start_addr_o !== 4'd4 || sif.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_start: got start=%0d busy=%b expected 4/0", sif.start_addr_o, sif.busy_o); end
        tests_run++; if (wr_count - base !== 20 || last_addr !== 4'd3) begin tests_failed++; $display("[TB] FAIL ramp_writes: got count=%0d last=%0d expected 20/3", wr_count - base, last_addr); end
        tests_run++; if (mem_img[8] !== 8'h80 || mem_img[15] !== 8'hF0) begin tests_failed++; $display("[TB] FAIL ramp_data: got [8]=%h [15]=%h expected 80/F0", mem_img[8], mem_img[15]); end
        cycle(1'b1, 8'h99, 1'b1);
        tests_run++; if (wr_count - base !== 20 || sif.done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_done_hold: got count=%0d done=%b expected 20/1", wr_count - base, sif.done_o); end
    endtask

    task automatic test_falling_pretrig0();
        int base;
        base = wr_count;
        do_arm(4'd0, 8'h40, EDGE_FALL);
        cycle(1'b1, 8'h50, 1'b0);
        cycle(1'b1, 8'h50, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL fall_no_trig: got %b expected 0", sif.triggered_o); end
        cycle(1'b1, 8'h40, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.trig_addr_o !== 4'd2) begin tests_failed++; $display("[TB] FAIL fall_trig: got trig=%b addr=%0d expected 1/2", sif.triggered_o, sif.trig_addr_o); end
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'h00, 1'b0);
        tests_run++; if (sif.done_o !== 1'b1 || sif.start_addr_o !== 4'd2) begin tests_failed++; $display("[TB] FAIL fall_done: got done=%b start=%0d expected 1/2", sif.done_o, sif.start_addr_o); end
        tests_run++; if (wr_count - base !== 18 || last_addr !== 4'd1) begin tests_failed++; $display("[TB] FAIL fall_writes: got count=%0d last=%0d expected 18/1", wr_count - base, last_addr); end
    endtask

    task automatic test_first_sample();
        do_arm(4'd0, 8'h80, EDGE_RISE);
        cycle(1'b1, 8'hFF, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_sample_immune: got %b expected 0", sif.triggered_o); end
        cycle(1'b1, 8'h00, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_sample_second: got %b expected 0", sif.triggered_o); end
        cycle(1'b1, 8'h90, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.trig_addr_o !== 4'd2) begin tests_failed++; $display("[TB] FAIL first_sample_third: got trig=%b addr=%0d expected 1/2", sif.triggered_o, sif.trig_addr_o); end
    endtask

    task automatic test_force();
        int base;
        base = wr_count;
        do_arm(4'd2, 8'h80, EDGE_RISE);
        cycle(1'b1, 8'h10, 1'b1);
        cycle(1'b1, 8'h10, 1'b1);
        tests_run++; if (sif.triggered_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL force_prefill: got %b expected 0", sif.triggered_o); end
        cycle(1'b0, 8'h10, 1'b1);
        tests_run++; if (sif.triggered_o !== 1'b0 || sif.mem_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL force_no_valid: got trig=%b we=%b expected 0/0", sif.triggered_o, sif.mem_we_o); end
        cycle(1'b1, 8'h10, 1'b1);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.trig_addr_o !== 4'd2) begin tests_failed++; $display("[TB] FAIL force_trig: got trig=%b addr=%0d expected 1/2", sif.triggered_o, sif.trig_addr_o); end
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'h10, 1'b0);
        tests_run++; if (sif.done_o !== 1'b1 || sif.start_addr_o !== 4'd0 || wr_count - base !== 16) begin tests_failed++; $display("[TB] FAIL force_done: got done=%b start=%0d count=%0d expected 1/0/16", sif.done_o, sif.start_addr_o, wr_count - base); end

        // Force and rising crossing on the same sample
        base = wr_count;
        do_arm(4'd0, 8'h80, EDGE_RISE);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h90, 1'b1);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.trig_addr_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL coincide_trig: got trig=%b addr=%0d expected 1/1", sif.triggered_o, sif.trig_addr_o); end
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'h90, 1'b0);
        tests_run++; if (sif.done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL coincide_early_done: got %b expected 0", sif.done_o); end
        cycle(1'b1, 8'h90, 1'b0);
        tests_run++; if (sif.done_o !== 1'b1 || sif.start_addr_o !== 4'd1 || wr_count - base !== 17) begin tests_failed++; $display("[TB] FAIL coincide_done: got done=%b start=%0d count=%0d expected 1/1/17", sif.done_o, sif.start_addr_o, wr_count - base); end
    endtask

    task automatic test_gapped_max_pretrig();
        int base;
        base = wr_count;
        do_arm(4'd15, 8'h80, EDGE_RISE);
        for (int k = 0; k < 15; k++) begin
            cycle(1'b1, 8'h20, 1'b0);
            cycle(1'b0, 8'hA0, 1'b0);
            cycle(1'b0, 8'hA0, 1'b0);
        end
        tests_run++; if (sif.triggered_o !== 1'b0 || sif.busy_o !== 1'b1 || wr_count - base !== 15) begin tests_failed++; $display("[TB] FAIL gap_prefill: got trig=%b busy=%b count=%0d expected 0/1/15", sif.triggered_o, sif.busy_o, wr_count - base); end
        cycle(1'b1, 8'hA0, 1'b0);
        tests_run++; if (sif.done_o !== 1'b1 || sif.mem_we_o !== 1'b1 || sif.triggered_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL gap_done_at_trig: got done=%b we=%b trig=%b expected 1/1/1", sif.done_o, sif.mem_we_o, sif.triggered_o); end
        tests_run++; if (sif.trig_addr_o !== 4'd15 || sif.start_addr_o !== 4'd0) begin tests_failed++; $display("[TB] FAIL gap_addrs: got trig=%0d start=%0d expected 15/0", sif.trig_addr_o, sif.start_addr_o); end
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        tests_run++; if (wr_count - base !== 16) begin tests_failed++; $display("[TB] FAIL gap_writes: got %0d expected 16", wr_count - base); end
    endtask

    task automatic test_rearm_and_reset();
        do_arm(4'd0, 8'h80, EDGE_RISE);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h90, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
        tests_run++; if (sif.triggered_o !== 1'b1 || sif.done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rearm_postfill: got trig=%b done=%b expected 1/0", sif.triggered_o, sif.done_o); end
        do_arm(4'd3, 8'h80, EDGE_RISE);
        tests_run++; if (sif.triggered_o !== 1'b0 || sif.done_o !== 1'b0 || sif.busy_o !== 1'b1 || sif.mem_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rearm_clear: got trig=%b done=%b busy=%b we=%b expected 0/0/1/0", sif.triggered_o, sif.done_o, sif.busy_o, sif.mem_we_o); end
        cycle(1'b1, 8'h55, 1'b0);
        tests_run++; if (sif.mem_we_o !== 1'b1 || sif.mem_addr_o !== 4'd0 || sif.mem_data_o !== 8'h55) begin tests_failed++; $display("[TB] FAIL rearm_first_write: got we=%b addr=%0d data=%h expected 1/0/55", sif.mem_we_o, sif.mem_addr_o, sif.mem_data_o); end
        cycle(1'b1, 8'h66, 1'b0);
        tests_run++; if (sif.mem_addr_o !== 4'd1 || sif.trig_addr_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL rearm_second_write: got addr=%0d trig_addr=%0d expected 1/1", sif.mem_addr_o, sif.trig_addr_o); end
        rst = 1'b1;
        sif.arm_i = 1'b1;
        cycle(1'b1, 8'h77, 1'b0);
        sif.arm_i = 1'b0;
        rst = 1'b0;
        tests_run++; if (sif.mem_we_o !== 1'b0 || sif.busy_o !== 1'b0 || sif.mem_addr_o !== 4'd0 || sif.mem_data_o !== 8'h00) begin tests_failed++; $display("[TB] FAIL midrst_bus: got we=%b busy=%b addr=%0d data=%h expected 0/0/0/00", sif.mem_we_o, sif.busy_o, sif.mem_addr_o, sif.mem_data_o); end
        tests_run++; if (sif.trig_addr_o !== 4'd0 || sif.start_addr_o !== 4'd0 || sif.triggered_o !== 1'b0 || sif.done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_status: got trig_addr=%0d start=%0d trig=%b done=%b expected 0/0/0/0", sif.trig_addr_o, sif.start_addr_o, sif.triggered_o, sif.done_o); end
        cycle(1'b1, 8'h88, 1'b0);
        tests_run++; if (sif.mem_we_o !== 1'b0 || sif.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_idle: got we=%b busy=%b expected 0/0", sif.mem_we_o, sif.busy_o); end
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        wr_count           = 0;
        last_addr          = '0;
        rst                = 1'b1;
        sif.sample_i       = '0;
        sif.sample_valid_i = 1'b0;
        sif.arm_i          = 1'b0;
        sif.force_i        = 1'b0;
        sif.trig_level_i   = '0;
        sif.trig_edge_i    = EDGE_RISE;
        sif.pretrig_i      = '0;
        for (int i = 0; i < 16; i++) mem_img[i] = '0;

        test_reset();
        test_rising_ramp();
        test_falling_pretrig0();
        test_first_sample();
        test_force();
        test_gapped_max_pretrig();
        test_rearm_and_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
